// File: rtl/nq_pkg.sv
// Shared types and constants for the write-back path: queue entry layout and
// register-file geometry.
package nq_pkg;

  localparam int NQ_DATA_W   = 16;
  localparam int NQ_REG_W    = 3;
  localparam int NQ_NUM_REGS = 8;

  typedef struct packed {
    logic [NQ_REG_W-1:0]  rd;
    logic [NQ_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of issue claim, ALU/load result offers, register-file write port and
// forwarding copy. master = producers/consumers around the unit, slave = the unit.
interface writeback_unit_if #(
  parameter int DATA_W = nq_pkg::NQ_DATA_W,
  parameter int REG_W  = nq_pkg::NQ_REG_W
);

  localparam int NUM_REGS = 1 << REG_W;

  logic                issue_valid;
  logic [REG_W-1:0]    issue_rd;
  logic                issue_ready;
  logic [NUM_REGS-1:0] pend;

  logic                alu_valid;
  logic [REG_W-1:0]    alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;

  logic                mem_valid;
  logic [REG_W-1:0]    mem_rd;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_ready;

  logic [REG_W-1:0]    rd;
  logic [DATA_W-1:0]   data_in;
  logic                write_reg;

  logic                byp_valid;
  logic [REG_W-1:0]    byp_rd;
  logic [DATA_W-1:0]   byp_data;

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  issue_ready, pend, alu_ready, mem_ready,
    input  rd, data_in, write_reg,
    input  byp_valid, byp_rd, byp_data
  );

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output issue_ready, pend, alu_ready, mem_ready,
    output rd, data_in, write_reg,
    output byp_valid, byp_rd, byp_data
  );

endinterface

// File: rtl/writeback_unit_fifo.sv
// Dual-push, single-pop queue of write-back entries. push1 is only meaningful
// together with push0 (second entry lands behind the first).
module wb_fifo
  import nq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  wb_entry_t                din0,
  input  logic                     push1,
  input  wb_entry_t                din1,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n_push;
  logic            pop_i;

  assign n_push = CW'(push0) + CW'(push1);
  assign pop_i  = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      rd_ptr <= rd_ptr + PW'(pop_i);
      cnt    <= cnt + n_push - CW'(pop_i);
    end
  end

  // Storage needs no reset: validity is carried entirely by cnt.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= din0;
    if (push1) mem[wr_ptr + PW'(1)] <= din1;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign free  = CW'(DEPTH) - cnt;

endmodule

// File: rtl/writeback_unit.sv
// Write-back queue feeding the register file: rd leads data_in/write_reg by one
// cycle, plus a per-register pending scoreboard for issue hazards.
module writeback_unit
  import nq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = NQ_DATA_W,
  parameter int REG_W  = NQ_REG_W
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             e_alu;
  wb_entry_t             e_mem;
  wb_entry_t             din0;
  wb_entry_t             head;
  wb_entry_t             a_entry;
  wb_entry_t             b_entry;
  logic                  a_valid;
  logic                  b_valid;
  logic                  alu_acc;
  logic                  mem_acc;
  logic                  push0;
  logic                  push1;
  logic                  pop;
  logic                  claim;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         fifo_free;
  logic [(1<<REG_W)-1:0] pend_q;
  logic [(1<<REG_W)-1:0] pend_nxt;

  // Free is pre-dequeue; mem needs a second slot only when ALU also claims one.
  assign bus.alu_ready = (fifo_free != '0);
  assign bus.mem_ready = bus.alu_valid ? (fifo_free >= CW'(2)) : (fifo_free != '0);

  assign alu_acc = bus.alu_valid & bus.alu_ready;
  assign mem_acc = bus.mem_valid & bus.mem_ready;

  assign e_alu.rd   = bus.alu_rd;
  assign e_alu.data = bus.alu_data;
  assign e_mem.rd   = bus.mem_rd;
  assign e_mem.data = bus.mem_data;

  assign push0 = alu_acc | mem_acc;
  assign push1 = alu_acc & mem_acc;
  assign din0  = alu_acc ? e_alu : e_mem;
  assign pop   = (fifo_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (e_mem),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .free  (fifo_free)
  );

  // Invalid stages hold zeroed entries so outputs come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      a_entry <= '0;
      b_valid <= 1'b0;
      b_entry <= '0;
    end else begin
      a_valid <= pop;
      a_entry <= pop ? head : '0;
      b_valid <= a_valid;
      b_entry <= a_entry;
    end
  end

  assign bus.rd        = a_entry.rd;
  assign bus.write_reg = b_valid;
  assign bus.data_in   = DATA_W'(b_entry.data);
  assign bus.byp_valid = b_valid;
  assign bus.byp_rd    = b_entry.rd;
  assign bus.byp_data  = b_entry.data;

  assign bus.issue_ready = !pend_q[bus.issue_rd];
  assign claim           = bus.issue_valid & bus.issue_ready;

  // Clear first so a claim landing on the commit edge keeps the bit set.
  always_comb begin
    pend_nxt = pend_q;
    if (b_valid) pend_nxt[b_entry.rd] = 1'b0;
    if (claim)   pend_nxt[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_nxt;
  end

  assign bus.pend = pend_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a small register-file model that
// latches rd one edge before the data.
module tb_writeback_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [15:0] rf [8];
  logic [2:0]  rd_q;

  writeback_unit_if #(.DATA_W(16), .REG_W(3)) bus ();

  writeback_unit #(.DEPTH(4), .DATA_W(16), .REG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      if (bus.write_reg) rf[rd_q] <= bus.data_in;
      rd_q <= bus.rd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_data    = '0;
  endtask

  task automatic alu(input logic [2:0] r, input logic [15:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = r;
    bus.alu_data  = d;
  endtask

  task automatic mem(input logic [2:0] r, input logic [15:0] d);
    bus.mem_valid = 1'b1;
    bus.mem_rd    = r;
    bus.mem_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", bus.rd, 0);
    chk("rst_data_in", bus.data_in, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_byp_valid", bus.byp_valid, 0);
    chk("rst_byp_data", bus.byp_data, 0);
    chk("rst_pend", bus.pend, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_mem_ready", bus.mem_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // single ALU write with a claim on the same register
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 3'd5;
    alu(3'd5, 16'hBEEF);
    #1;
    chk("single_claim_ready", bus.issue_ready, 1);
    chk("single_alu_ready", bus.alu_ready, 1);
    @(negedge clk);
    idle();
    #1;
    chk("single_pend_set", bus.pend, 8'h20);
    chk("single_rd_e0", bus.rd, 0);
    @(negedge clk);
    chk("single_rd_e1", bus.rd, 5);
    chk("single_wr_e1", bus.write_reg, 0);
    @(negedge clk);
    chk("single_wr_e2", bus.write_reg, 1);
    chk("single_data_e2", bus.data_in, 16'hBEEF);
    chk("single_byp_valid", bus.byp_valid, 1);
    chk("single_byp_rd", bus.byp_rd, 5);
    chk("single_byp_data", bus.byp_data, 16'hBEEF);
    chk("single_pend_held", bus.pend, 8'h20);
    @(negedge clk);
    chk("single_pend_clr", bus.pend, 0);
    chk("single_wr_e3", bus.write_reg, 0);
    chk("single_data_e3", bus.data_in, 0);
    chk("single_rf5", rf[5], 16'hBEEF);

    // simultaneous offers into an empty queue
    alu(3'd1, 16'h0011);
    mem(3'd2, 16'h0022);
    #1;
    chk("dual_alu_ready", bus.alu_ready, 1);
    chk("dual_mem_ready", bus.mem_ready, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("dual_rd_first", bus.rd, 1);
    @(negedge clk);
    chk("dual_wr_first", bus.write_reg, 1);
    chk("dual_data_first", bus.data_in, 16'h0011);
    chk("dual_byp_rd_first", bus.byp_rd, 1);
    chk("dual_rd_second", bus.rd, 2);
    @(negedge clk);
    chk("dual_data_second", bus.data_in, 16'h0022);
    chk("dual_byp_rd_second", bus.byp_rd, 2);
    chk("dual_rd_idle", bus.rd, 0);
    @(negedge clk);
    chk("dual_wr_done", bus.write_reg, 0);
    chk("dual_rf1", rf[1], 16'h0011);
    chk("dual_rf2", rf[2], 16'h0022);

    // continuous ALU stream with the drain running
    for (int i = 0; i < 6; i++) begin
      alu(3'd4, 16'h0400 + 16'(i));
      #1;
      chk("bp_alu_hold", bus.alu_ready, 1);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);
    chk("bp_rf4_stream", rf[4], 16'h0405);

    // fill to one free slot with both offers, mem must be held off
    alu(3'd4, 16'h0A01);
    mem(3'd6, 16'h0B01);
    #1;
    chk("bp_free4_alu", bus.alu_ready, 1);
    chk("bp_free4_mem", bus.mem_ready, 1);
    @(negedge clk);
    alu(3'd4, 16'h0A02);
    mem(3'd6, 16'h0B02);
    #1;
    chk("bp_free2_mem", bus.mem_ready, 1);
    @(negedge clk);
    alu(3'd4, 16'h0A03);
    mem(3'd6, 16'h0B03);
    #1;
    chk("bp_free1_alu", bus.alu_ready, 1);
    chk("bp_free1_mem", bus.mem_ready, 0);
    @(negedge clk);
    alu(3'd4, 16'h0A04);
    mem(3'd6, 16'h0B04);
    #1;
    chk("bp_free1_again_mem", bus.mem_ready, 0);
    @(negedge clk);
    idle();
    repeat (8) @(negedge clk);
    chk("bp_rf4_alu_taken", rf[4], 16'h0A04);
    chk("bp_rf6_mem_held", rf[6], 16'h0B02);
    chk("bp_drained_wr", bus.write_reg, 0);

    // scoreboard: claim, duplicate claim, commit clear
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 3'd3;
    #1;
    chk("sb_claim_ready", bus.issue_ready, 1);
    @(negedge clk);
    chk("sb_pend3", bus.pend, 8'h08);
    chk("sb_dup_blocked", bus.issue_ready, 0);
    idle();
    alu(3'd3, 16'h3333);
    @(negedge clk);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("sb_commit_wr", bus.write_reg, 1);
    chk("sb_pend_before_commit", bus.pend, 8'h08);
    @(negedge clk);
    chk("sb_pend_cleared", bus.pend, 0);

    // unclaimed write to r3, with a fresh claim landing on its commit edge
    alu(3'd3, 16'h4444);
    @(negedge clk);
    idle();
    #1;
    chk("sb_unclaimed_pend", bus.pend, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_setwin_wr", bus.write_reg, 1);
    chk("sb_setwin_byp_rd", bus.byp_rd, 3);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 3'd3;
    #1;
    chk("sb_setwin_ready", bus.issue_ready, 1);
    @(negedge clk);
    idle();
    chk("sb_setwin_pend", bus.pend, 8'h08);
    chk("sb_rf3", rf[3], 16'h4444);
    @(negedge clk);
    chk("sb_setwin_pend_hold", bus.pend, 8'h08);

    // same register written twice
    alu(3'd7, 16'h0001);
    @(negedge clk);
    alu(3'd7, 16'h0002);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("ord_byp_first", bus.byp_data, 16'h0001);
    chk("ord_byp_rd", bus.byp_rd, 7);
    @(negedge clk);
    chk("ord_byp_second", bus.byp_data, 16'h0002);
    @(negedge clk);
    chk("ord_rf7", rf[7], 16'h0002);
    chk("ord_wr_done", bus.write_reg, 0);

    // reset with three results queued or in flight
    alu(3'd1, 16'h0C01);
    mem(3'd2, 16'h0C02);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 3'd6;
    @(negedge clk);
    idle();
    alu(3'd4, 16'h0C03);
    @(negedge clk);
    idle();
    chk("mid_rd_before", bus.rd, 1);
    chk("mid_pend_before", bus.pend, 8'h48);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rd", bus.rd, 0);
    chk("mid_write_reg", bus.write_reg, 0);
    chk("mid_data_in", bus.data_in, 0);
    chk("mid_byp_valid", bus.byp_valid, 0);
    chk("mid_byp_rd", bus.byp_rd, 0);
    chk("mid_byp_data", bus.byp_data, 0);
    chk("mid_pend", bus.pend, 0);
    chk("mid_alu_ready", bus.alu_ready, 1);
    chk("mid_mem_ready", bus.mem_ready, 1);
    chk("mid_issue_ready", bus.issue_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_write", bus.write_reg, 0);
      chk("mid_no_rd", bus.rd, 0);
    end
    chk("mid_pend_after", bus.pend, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
